// File: rtl/md_unit_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
// The D-stage decoder and stall unit use the same md_op encodings.
package md_unit_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Larger of the two latencies; sizes the busy down-counter.
  function automatic int max_cycles(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 32x32 multiply/divide datapath.
// Multiply: result = {hi, lo} product. Divide: result = {remainder, quotient},
// quotient truncated toward zero, remainder carries the dividend's sign.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] result_o,
  output logic        div_by_zero_o
);

  logic        signed_op;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        q_neg;
  logic        r_neg;

  // Shared sign handling, then select the product or the quotient/remainder pair.
  always_comb begin
    signed_op = (op_i == MD_MULT) || (op_i == MD_DIV);
    // Sign/zero extension to 64 bits makes the low 64 product bits exact for both flavours.
    a_ext = {{32{signed_op & a_i[31]}}, a_i};
    b_ext = {{32{signed_op & b_i[31]}}, b_i};
    prod  = a_ext * b_ext;

    a_mag = (signed_op && a_i[31]) ? (32'd0 - a_i) : a_i;
    b_mag = (signed_op && b_i[31]) ? (32'd0 - b_i) : b_i;

    div_by_zero_o = (b_i == 32'd0);
    // Guarded divider input keeps the datapath well defined when the divisor is zero.
    if (div_by_zero_o) begin
      q_mag = 32'd0;
      r_mag = 32'd0;
    end else begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end

    // 0x80000000 / -1 yields magnitude 0x80000000 with positive sign, which wraps to 0x80000000.
    q_neg = signed_op & (a_i[31] ^ b_i[31]);
    r_neg = signed_op & a_i[31];

    if ((op_i == MD_MULT) || (op_i == MD_MULTU)) begin
      result_o = prod;
    end else begin
      result_o = {(r_neg ? (32'd0 - r_mag) : r_mag),
                  (q_neg ? (32'd0 - q_mag) : q_mag)};
    end
  end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with fixed-latency commit to architectural HI/LO.
// Results are computed at acceptance, held in pend_*, and committed when
// the down-counter expires.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(max_cycles(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [63:0] calc_result;
  logic        calc_dz;
  logic        accept;

  md_calc u_md_calc (
    .op_i          (md_op),
    .a_i           (a),
    .b_i           (b),
    .result_o      (calc_result),
    .div_by_zero_o (calc_dz)
  );

  assign busy     = (cnt_q != CNT_ZERO);
  assign md_stall = start | busy;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign accept   = start & ~busy;

  // Next-state: accept a new op when idle, otherwise count down and commit on expiry.
  always_comb begin
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    cnt_d     = cnt_q;
    if (accept) begin
      case (md_op)
        MD_MULT, MD_MULTU: begin
          {pend_hi_d, pend_lo_d} = calc_result;
          pend_dz_d = 1'b0;
          cnt_d     = MULT_LOAD;
        end
        MD_DIV, MD_DIVU: begin
          {pend_hi_d, pend_lo_d} = calc_result;
          pend_dz_d = calc_dz;
          cnt_d     = DIV_LOAD;
        end
        MD_MTHI: hi_d = a;
        MD_MTLO: lo_d = a;
        default: ;
      endcase
    end else if (cnt_q > CNT_ONE) begin
      cnt_d = cnt_q - CNT_ONE;
    end else if (cnt_q == CNT_ONE) begin
      cnt_d = CNT_ZERO;
      // A zero divisor still takes the full latency but leaves HI/LO untouched.
      if (!pend_dz_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_dz_q <= 1'b0;
      cnt_q     <= CNT_ZERO;
    end else begin
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random ops,
// compared each cycle against a timestamp-based behavioural model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: architectural values, pending result, and the edge index at which it lands.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] m_phi = 32'd0;
  logic [31:0] m_plo = 32'd0;
  logic        m_pwr = 1'b0;
  int          edge_n = 0;
  int          done_edge = 0;

  md_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic m_busy();
    return edge_n < done_edge;
  endfunction

  // Apply one rising edge to the model.
  task automatic model_edge(input logic st, input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    logic   was_busy;
    longint sa, sb, sp, sq, sr;
    logic [63:0] up;
    was_busy = m_busy();
    edge_n++;
    if (edge_n == done_edge && m_pwr) begin
      m_hi = m_phi;
      m_lo = m_plo;
    end
    if (st && !was_busy) begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      case (op)
        3'd0: begin
          sp = sa * sb;
          m_phi = sp[63:32]; m_plo = sp[31:0]; m_pwr = 1'b1;
          done_edge = edge_n + 5;
        end
        3'd1: begin
          up = {32'd0, av} * {32'd0, bv};
          m_phi = up[63:32]; m_plo = up[31:0]; m_pwr = 1'b1;
          done_edge = edge_n + 5;
        end
        3'd2: begin
          m_pwr = (bv != 32'd0);
          if (m_pwr) begin
            sq = sa / sb; sr = sa % sb;
            m_plo = sq[31:0]; m_phi = sr[31:0];
          end
          done_edge = edge_n + 10;
        end
        3'd3: begin
          m_pwr = (bv != 32'd0);
          if (m_pwr) begin
            m_plo = av / bv; m_phi = av % bv;
          end
          done_edge = edge_n + 10;
        end
        3'd4: m_hi = av;
        3'd5: m_lo = av;
        default: ;
      endcase
    end
  endtask

  task automatic do_cycle(input logic st, input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = st; md_op = op; a = av; b = bv;
    #1;
    chk("md_stall", {31'd0, md_stall}, {31'd0, st | m_busy()});
    @(posedge clk);
    model_edge(st, op, av, bv);
    #1;
    chk("busy", {31'd0, busy}, {31'd0, m_busy()});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  endtask

  // Asynchronous reset pulse landing mid-cycle, spanning one rising edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    start = 1'b0;
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0; m_pwr = 1'b0; done_edge = edge_n;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    start = 1'b1;
    #1;
    chk("rst_stall", {31'd0, md_stall}, 32'd1);
    start = 1'b0;
    @(posedge clk);
    edge_n++;
    #3;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; a = 32'd0; b = 32'd0;
    #12;
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_hi", hi, 32'd0);
    chk("init_lo", lo, 32'd0);
    start = 1'b1;
    #1;
    chk("init_stall", {31'd0, md_stall}, 32'd1);
    start = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b0;

    // mult -3 * 5
    do_cycle(1'b1, 3'd0, 32'hFFFF_FFFD, 32'd5);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 3'd0, 32'd0, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    // multu 0xFFFFFFFF * 2
    do_cycle(1'b1, 3'd1, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 5; i++) do_cycle(1'b0, 3'd0, 32'd0, 32'd0);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    // div -7 / 2, then divu 7 / 0 back-to-back
    do_cycle(1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 3'd0, 32'd0, 32'd0);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    do_cycle(1'b1, 3'd3, 32'd7, 32'd0);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 3'd0, 32'd0, 32'd0);
    chk("divz_hi", hi, 32'hFFFF_FFFF);
    chk("divz_lo", lo, 32'hFFFF_FFFD);
    // div overflow case
    do_cycle(1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 10; i++) do_cycle(1'b0, 3'd0, 32'd0, 32'd0);
    chk("divov_hi", hi, 32'h0000_0000);
    chk("divov_lo", lo, 32'h8000_0000);
    // mthi / mtlo back-to-back
    do_cycle(1'b1, 3'd4, 32'h1234_5678, 32'd0);
    chk("mthi", hi, 32'h1234_5678);
    do_cycle(1'b1, 3'd5, 32'h9ABC_DEF0, 32'd0);
    chk("mtlo", lo, 32'h9ABC_DEF0);
    // mult, then divu held on start while busy (ignored)
    do_cycle(1'b1, 3'd0, 32'd6, 32'd7);
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 3'd3, 32'd100, 32'd3);
    do_cycle(1'b0, 3'd0, 32'd0, 32'd0);
    chk("ign_lo", lo, 32'd42);
    chk("ign_hi", hi, 32'd0);
    // multu, reset two cycles in, no commit afterwards
    do_cycle(1'b1, 3'd1, 32'hDEAD_BEEF, 32'd3);
    do_cycle(1'b0, 3'd0, 32'd0, 32'd0);
    do_reset();
    for (int i = 0; i < 6; i++) do_cycle(1'b0, 3'd0, 32'd0, 32'd0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    // Random traffic, including ops issued while busy and unlisted opcodes.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        do_cycle($urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), pick_operand(), pick_operand());
      end
    end
    for (int i = 0; i < 12; i++) do_cycle(1'b0, 3'd0, 32'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
